// File: rtl/chat_pkg.sv
// chat_pkg: shared types and constants for the multi-channel chatter filter.
package chat_pkg;
    typedef enum logic {CHAT_BLANK = 1'b0, CHAT_DEBOUNCE = 1'b1} chat_mode_e;
    typedef enum logic {CH_IDLE, CH_COUNT} ch_state_e;
    localparam logic RST_LEVEL = 1'b1;
endpackage

// File: rtl/chat_filter_ch.sv
// chat_filter_ch: one channel -- synchroniser, blank/debounce FSM, hold counter, edge pulses.
module chat_filter_ch
    import chat_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int HOLD        = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       abort,
    input  chat_mode_e mode,
    input  logic       in,
    output logic       out,
    output logic       rise,
    output logic       fall,
    output logic       busy
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD - 1);

    logic [SYNC_STAGES-1:0] sync;
    ch_state_e              state;
    logic [CNT_W-1:0]       cnt;
    logic                   cand;
    logic                   s;

    assign s    = sync[SYNC_STAGES-1];
    assign busy = (state == CH_COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= {SYNC_STAGES{RST_LEVEL}};
            out   <= RST_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            state <= CH_IDLE;
            cnt   <= '0;
            cand  <= RST_LEVEL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en) begin
                state <= CH_IDLE;
                cnt   <= '0;
                out   <= s;
                rise  <= s & ~out;
                fall  <= ~s & out;
            end else if (abort) begin
                state <= CH_IDLE;
                cnt   <= '0;
            end else if (mode == CHAT_BLANK) begin
                // a falling edge passes at once, then out is pinned low for HOLD cycles
                if (state == CH_IDLE) begin
                    out  <= s;
                    rise <= s & ~out;
                    fall <= ~s & out;
                    if (!s && out) begin
                        state <= CH_COUNT;
                        cnt   <= LOAD;
                    end
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    out   <= s;
                    rise  <= s;
                    state <= CH_IDLE;
                end
            end else begin
                if (state == CH_IDLE) begin
                    if (s != out) begin
                        cand  <= s;
                        cnt   <= LOAD;
                        state <= CH_COUNT;
                    end
                end else if (s != cand) begin
                    state <= CH_IDLE;
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    out   <= cand;
                    rise  <= cand & ~out;
                    fall  <= ~cand & out;
                    state <= CH_IDLE;
                end
            end
        end
    end
endmodule

// File: rtl/chat_filter_multi.sv
// chat_filter_multi: CH independent chatter filters sharing enable, mode and reset.
module chat_filter_multi
    import chat_pkg::*;
#(
    parameter int CH          = 4,
    parameter int CNT_W       = 4,
    parameter int HOLD        = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] busy
);
    chat_mode_e mode_q;
    logic       abort;

    if (HOLD < 1 || HOLD > 2**CNT_W - 1) begin : g_hold_check
        $error("chat_filter_multi: HOLD must be in 1..2**CNT_W-1");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("chat_filter_multi: SYNC_STAGES must be at least 2");
    end

    // a mode change drops every channel back to IDLE for one cycle
    assign abort = (chat_mode_e'(mode) != mode_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mode_q <= CHAT_BLANK;
        else      mode_q <= chat_mode_e'(mode);
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        chat_filter_ch #(
            .CNT_W(CNT_W),
            .HOLD(HOLD),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .en(en),
            .abort(abort),
            .mode(mode_q),
            .in(in[i]),
            .out(out[i]),
            .rise(rise[i]),
            .fall(fall[i]),
            .busy(busy[i])
        );
    end
endmodule

// File: tb/tb_chat_filter_multi.sv
// tb_chat_filter_multi: randomized scenarios checked against a behavioural model of the filter rules.
module tb_chat_filter_multi;
    localparam int CH = 4;
    localparam int CNT_W = 4;
    localparam int HOLD = 15;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          mode = 1'b0;
    logic [CH-1:0] in = '1;
    logic [CH-1:0] out, rise, fall, busy;

    int checks = 0;
    int failures = 0;

    chat_filter_multi #(.CH(CH), .CNT_W(CNT_W), .HOLD(HOLD), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
        .out(out), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    // model: blank = cycles of forced-low time remaining, run = consecutive samples differing from out
    logic [CH-1:0] m_sync [SS];
    logic [CH-1:0] m_out, m_rise, m_fall;
    int            m_blank [CH];
    int            m_run [CH];
    logic          m_mode_q;

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sync[k] = '1;
        m_out = '1; m_rise = '0; m_fall = '0; m_mode_q = 1'b0;
        for (int i = 0; i < CH; i++) begin m_blank[i] = 0; m_run[i] = 0; end
    endtask

    task automatic model_step();
        logic [CH-1:0] s, prev;
        s = m_sync[SS-1];
        for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = in;
        prev = m_out;
        for (int i = 0; i < CH; i++) begin
            if (!en) begin
                m_out[i] = s[i]; m_blank[i] = 0; m_run[i] = 0;
            end else if (mode != m_mode_q) begin
                m_blank[i] = 0; m_run[i] = 0;
            end else if (!m_mode_q) begin
                if (m_blank[i] > 0) begin
                    m_blank[i]--;
                    if (m_blank[i] == 0) m_out[i] = s[i];
                end else if (m_out[i] && !s[i]) begin
                    m_out[i] = 1'b0; m_blank[i] = HOLD;
                end else m_out[i] = s[i];
            end else begin
                if (s[i] == m_out[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == HOLD + 1) begin m_out[i] = s[i]; m_run[i] = 0; end
                end
            end
        end
        m_mode_q = mode;
        m_rise = m_out & ~prev;
        m_fall = ~m_out & prev;
    endtask

    function automatic logic [4*CH-1:0] expv();
        logic [CH-1:0] b;
        for (int i = 0; i < CH; i++) b[i] = (m_blank[i] > 0) || (m_run[i] > 0);
        return {m_out, m_rise, m_fall, b};
    endfunction

    task automatic tick();
        if (!rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4*CH-1:0] got;
        rst = 1'b0; in = '0; model_reset();
        repeat (3) tick();
        got = {out, rise, fall, busy};
        checks++;
        if (got !== {4'hF, 4'h0, 4'h0, 4'h0}) begin
            failures++; $display("FAIL reset_values got=%h exp=%h", got, {4'hF, 12'h0});
        end
        rst = 1'b1; in = '1;
        for (int k = 0; k < 6; k++) begin
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv() || got !== {4'hF, 12'h0}) begin
                failures++; $display("FAIL reset_release k=%0d got=%h exp=%h", k, got, expv());
            end
        end
    endtask

    task automatic test_blank();
        int nfall = 0, nrise = 0, nlow = 0, nbusy = 0, fall_at = -1;
        logic [4*CH-1:0] got;
        mode = 1'b0; en = 1'b1;
        for (int k = 0; k < 36; k++) begin
            in[0] = (k == 0) ? 1'b0 : (k < 11) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL blank_model k=%0d got=%h exp=%h", k, got, expv());
            end
            if (fall[0]) begin nfall++; fall_at = k + 1; end
            nrise += int'(rise[0]); nlow += int'(!out[0]); nbusy += int'(busy[0]);
        end
        checks++;
        if (nfall != 1 || fall_at != SS + 1) begin
            failures++; $display("FAIL blank_fall count=%0d at=%0d exp 1 at %0d", nfall, fall_at, SS + 1);
        end
        checks++;
        if (nlow != HOLD || nbusy != HOLD) begin
            failures++; $display("FAIL blank_hold low=%0d busy=%0d exp=%0d", nlow, nbusy, HOLD);
        end
        checks++;
        if (nrise != 1) begin
            failures++; $display("FAIL blank_rise count=%0d exp=1", nrise);
        end
    endtask

    task automatic test_debounce();
        int npulse = 0, nbusy = 0, nfall = 0, nrise = 0, fall_at = -1, rise_at = -1;
        logic [4*CH-1:0] got;
        mode = 1'b1;
        for (int k = 0; k < 68; k++) begin
            in[1] = (k < 2) ? 1'b1 : (k < 7) ? 1'b0 : (k < 12) ? 1'b1 : (k < 32) ? 1'b0 : 1'b1;
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL debounce_model k=%0d got=%h exp=%h", k, got, expv());
            end
            if (k < 12) begin
                npulse += int'(rise[1]) + int'(fall[1]) + int'(!out[1]);
                nbusy += int'(busy[1]);
            end else begin
                if (fall[1]) begin nfall++; fall_at = k - 11; end
                if (rise[1]) begin nrise++; rise_at = k - 31; end
            end
        end
        checks++;
        if (npulse != 0 || nbusy > 5) begin
            failures++; $display("FAIL debounce_glitch changes=%0d busy=%0d exp 0 and <=5", npulse, nbusy);
        end
        checks++;
        if (nfall != 1 || fall_at != SS + 1 + HOLD) begin
            failures++; $display("FAIL debounce_fall count=%0d at=%0d exp 1 at %0d", nfall, fall_at, SS + 1 + HOLD);
        end
        checks++;
        if (nrise != 1 || rise_at != SS + 1 + HOLD) begin
            failures++; $display("FAIL debounce_rise count=%0d at=%0d exp 1 at %0d", nrise, rise_at, SS + 1 + HOLD);
        end
    endtask

    task automatic test_independence();
        int nfall = 0, nrise = 0, nlow2 = 0;
        logic [4*CH-1:0] got;
        mode = 1'b1;
        for (int k = 0; k < 90; k++) begin
            in[2] = (k % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in[3] = (k < 30) ? 1'b0 : 1'b1;
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL indep_model k=%0d got=%h exp=%h", k, got, expv());
            end
            nfall += int'(fall[3]); nrise += int'(rise[3]); nlow2 += int'(!out[2]);
        end
        in[2] = 1'b1;
        checks++;
        if (nfall != 1 || nrise != 1) begin
            failures++; $display("FAIL indep_ch3 falls=%0d rises=%0d exp 1/1", nfall, nrise);
        end
        checks++;
        if (nlow2 != 0) begin
            failures++; $display("FAIL indep_ch2 low_cycles=%0d exp=0", nlow2);
        end
    endtask

    task automatic test_mode_flip();
        int nfall = 0, nrise = 0;
        logic [4*CH-1:0] got;
        mode = 1'b0; in = '1;
        repeat (2) tick();
        in[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL flip_model k=%0d got=%h exp=%h", k, got, expv());
            end
        end
        mode = 1'b1;
        tick();
        checks++;
        if (busy[0] !== 1'b0 || out[0] !== 1'b0) begin
            failures++; $display("FAIL flip_abort busy=%b out=%b exp busy=0 out=0", busy[0], out[0]);
        end
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k < 16) in[0] = ((k / 2) % 2 == 0);
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL bypass_model k=%0d got=%h exp=%h", k, got, expv());
            end
            nfall += int'(fall[0]); nrise += int'(rise[0]);
        end
        checks++;
        if (nrise != 4 || nfall != 4) begin
            failures++; $display("FAIL bypass_pulses rises=%0d falls=%0d exp 4/4", nrise, nfall);
        end
        en = 1'b1; in = '1;
        repeat (25) tick();
    endtask

    task automatic test_reset_mid();
        int nfall = 0;
        logic [4*CH-1:0] got;
        mode = 1'b1; in[0] = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy[0] !== 1'b1) begin
            failures++; $display("FAIL midrst_pre busy=%b exp=1", busy[0]);
        end
        #1 rst = 1'b0; model_reset();
        #1 got = {out, rise, fall, busy};
        checks++;
        if (got !== {4'hF, 12'h0}) begin
            failures++; $display("FAIL midrst_values got=%h exp=%h", got, {4'hF, 12'h0});
        end
        #1 rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL midrst_model k=%0d got=%h exp=%h", k, got, expv());
            end
            nfall += int'(fall[0]);
        end
        checks++;
        if (nfall != 1) begin
            failures++; $display("FAIL midrst_resume falls=%0d exp=1", nfall);
        end
        in = '1;
        repeat (20) tick();
    endtask

    task automatic test_random();
        logic [4*CH-1:0] got;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 99) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) mode = ~mode;
            for (int i = 0; i < CH; i++) in[i] = in[i] ^ ($urandom_range(0, 3 + 12 * i) == 0);
            tick();
            got = {out, rise, fall, busy};
            checks++;
            if (got !== expv()) begin
                failures++; $display("FAIL random_model k=%0d got=%h exp=%h", k, got, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_debounce();
        test_independence();
        test_mode_flip();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
